// File: rtl/nn_seq_pkg.sv
// Shared types and constants for the neural_network sequencer.
//   state_t      : sequencer FSM states
//   *_DEF        : default geometry and the index widths derived from it
//   PERF_W       : width of the optional busy-cycle counter
package nn_seq_pkg;

    localparam int unsigned LAYER_SIZE_DEF  = 4;
    localparam int unsigned LAYER_DEPTH_DEF = 4;
    localparam int unsigned NODE_W_DEF      = $clog2(LAYER_SIZE_DEF);
    localparam int unsigned LAYER_W_DEF     = $clog2(LAYER_DEPTH_DEF);
    localparam int unsigned PERF_W          = 32;

    // StAbort is the single clean-up cycle that strobes nn_rst before IDLE.
    typedef enum logic [2:0] {
        StIdle,
        StLoadW,
        StClear,
        StFeed,
        StRun,
        StDrain,
        StAbort
    } state_t;

endpackage

// File: rtl/nn_idx_counter.sv
// Two-dimensional layer/node index counter shared by weight load, input feed
// and result drain.
//   clk, rst   : clock, asynchronous active-high reset
//   clr        : synchronous clear to (0,0); wins over en
//   en         : advance node by one; a node wrap advances the layer
//   layer/node : current index
//   node_last  : node == LAYER_SIZE-1
//   last       : layer == LAYER_DEPTH-1 and node == LAYER_SIZE-1
module nn_idx_counter
    import nn_seq_pkg::*;
#(
    parameter int unsigned LAYER_SIZE  = LAYER_SIZE_DEF,
    parameter int unsigned LAYER_DEPTH = LAYER_DEPTH_DEF
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           clr,
    input  logic                           en,
    output logic [$clog2(LAYER_DEPTH)-1:0] layer,
    output logic [$clog2(LAYER_SIZE)-1:0]  node,
    output logic                           node_last,
    output logic                           last
);

    logic [$clog2(LAYER_DEPTH)-1:0] layer_q;
    logic [$clog2(LAYER_SIZE)-1:0]  node_q;

    // Both dimensions are powers of two, so natural binary wrap is the modulo.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            layer_q <= '0;
            node_q  <= '0;
        end else if (clr) begin
            layer_q <= '0;
            node_q  <= '0;
        end else if (en) begin
            node_q <= node_q + 1'b1;
            if (&node_q) begin
                layer_q <= layer_q + 1'b1;
            end
        end
    end

    assign layer     = layer_q;
    assign node      = node_q;
    assign node_last = &node_q;
    assign last      = (&node_q) & (&layer_q);

endmodule

// File: rtl/nn_sequencer.sv
// Sequencer driving one neural_network datapath through a full inference:
// optional weight load, state clear, input feed, compute wait, result drain.
// Optional macro NNSEQ_PERF_CNT_EN adds the cycle_count output.
//   clk, rst                 : clock, asynchronous active-high reset
//   start, load_w, abort     : control; start/load_w sampled only in IDLE
//   busy, done               : status; done pulses after the last result
//   w_valid/w_ready/w_data   : weight stream in
//   x_valid/x_ready/x_data   : input stream in
//   y_valid/y_ready/y_data   : result stream out
//   nn_rst, nn_write_enable, nn_input_select, nn_layer, nn_node, nn_x : to datapath
//   nn_y                     : datapath result word, selected by nn_node
//   cycle_count              : busy cycles of the current/last run (macro only)
module nn_sequencer
    import nn_seq_pkg::*;
#(
    parameter int unsigned LAYER_SIZE  = LAYER_SIZE_DEF,
    parameter int unsigned LAYER_DEPTH = LAYER_DEPTH_DEF,
    parameter int unsigned BIT_SIZE    = 16,
    parameter int unsigned PIPE_LAT    = 4
) (
    input  logic                           clk,
    input  logic                           rst,
    input  logic                           start,
    input  logic                           load_w,
    input  logic                           abort,
    output logic                           busy,
    output logic                           done,
    input  logic                           w_valid,
    output logic                           w_ready,
    input  logic [BIT_SIZE-1:0]            w_data,
    input  logic                           x_valid,
    output logic                           x_ready,
    input  logic [BIT_SIZE-1:0]            x_data,
    output logic                           y_valid,
    input  logic                           y_ready,
    output logic [BIT_SIZE-1:0]            y_data,
    output logic                           nn_rst,
    output logic                           nn_write_enable,
    output logic                           nn_input_select,
    output logic [$clog2(LAYER_DEPTH)-1:0] nn_layer,
    output logic [$clog2(LAYER_SIZE)-1:0]  nn_node,
    output logic [BIT_SIZE-1:0]            nn_x,
    input  logic [BIT_SIZE-1:0]            nn_y
`ifdef NNSEQ_PERF_CNT_EN
    ,
    output logic [PERF_W-1:0]              cycle_count
`endif
);

    localparam int unsigned RUN_W = $clog2(PIPE_LAT + 1);

    state_t state_q, state_d;

    logic                           abort_take;
    logic                           hs_w, hs_x, hs_y;
    logic                           run_exit;
    logic [RUN_W-1:0]               run_cnt_q;
    logic                           idx_clr, idx_en;
    logic [$clog2(LAYER_DEPTH)-1:0] idx_layer;
    logic [$clog2(LAYER_SIZE)-1:0]  idx_node;
    logic                           idx_node_last, idx_last;

    assign busy    = (state_q != StIdle);
    assign w_ready = (state_q == StLoadW);
    assign x_ready = (state_q == StFeed);
    assign y_valid = (state_q == StDrain);

    // Abort outranks any handshake in the same cycle.
    assign abort_take = abort && (state_q != StIdle);
    assign hs_w       = w_valid && w_ready && !abort;
    assign hs_x       = x_valid && x_ready && !abort;
    assign hs_y       = y_valid && y_ready && !abort;
    assign run_exit   = (state_q == StRun) && (run_cnt_q == RUN_W'(1));

    // Counter is held at (0,0) outside the three streaming states.
    assign idx_clr = abort_take || (state_q inside {StIdle, StClear, StRun, StAbort});
    assign idx_en  = hs_w || hs_x || hs_y;

    nn_idx_counter #(
        .LAYER_SIZE  (LAYER_SIZE),
        .LAYER_DEPTH (LAYER_DEPTH)
    ) u_idx (
        .clk       (clk),
        .rst       (rst),
        .clr       (idx_clr),
        .en        (idx_en),
        .layer     (idx_layer),
        .node      (idx_node),
        .node_last (idx_node_last),
        .last      (idx_last)
    );

    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (start) state_d = load_w ? StLoadW : StClear;
            StLoadW: if (hs_w && idx_last) state_d = StClear;
            StClear: state_d = StFeed;
            StFeed:  if (hs_x && idx_node_last) state_d = StRun;
            StRun:   if (run_exit) state_d = StDrain;
            StDrain: if (hs_y && idx_node_last) state_d = StIdle;
            StAbort: state_d = StIdle;
            default: state_d = StIdle;
        endcase
        if (abort_take && (state_q != StAbort)) begin
            state_d = StAbort;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Counts down the remaining RUN cycles; RUN lasts exactly PIPE_LAT cycles.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run_cnt_q <= '0;
        end else if ((state_d == StRun) && (state_q != StRun)) begin
            run_cnt_q <= RUN_W'(PIPE_LAT);
        end else if (state_q == StRun) begin
            run_cnt_q <= run_cnt_q - 1'b1;
        end
    end

    // Datapath-facing registers. In RUN/DRAIN nn_node points one result ahead of
    // y_data so that nn_y already holds the next word when a handshake captures it.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            done            <= 1'b0;
            nn_rst          <= 1'b0;
            nn_write_enable <= 1'b0;
            nn_input_select <= 1'b1;
            nn_layer        <= '0;
            nn_node         <= '0;
            nn_x            <= '0;
            y_data          <= '0;
        end else begin
            done            <= hs_y && idx_node_last;
            nn_rst          <= state_d inside {StClear, StAbort};
            nn_write_enable <= hs_w;
            nn_input_select <= !(state_d inside {StRun, StDrain});
            if (abort_take) begin
                nn_layer <= '0;
                nn_node  <= '0;
            end else if (hs_w) begin
                nn_x     <= w_data;
                nn_layer <= idx_layer;
                nn_node  <= idx_node;
            end else if (hs_x) begin
                nn_x     <= x_data;
                nn_layer <= '0;
                // The last input leaves the index at result 0, ready for DRAIN.
                nn_node  <= idx_node_last ? '0 : idx_node;
            end else if (run_exit || hs_y) begin
                y_data  <= nn_y;
                nn_node <= nn_node + 1'b1;
            end
        end
    end

`ifdef NNSEQ_PERF_CNT_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cycle_count <= '0;
        end else if ((state_q == StIdle) && start) begin
            cycle_count <= '0;
        end else if (busy && (cycle_count != '1)) begin
            cycle_count <= cycle_count + 1'b1;
        end
    end
`endif

endmodule

// File: tb/tb_nn_sequencer.sv
module tb_nn_sequencer;

    localparam int LS = 4;
    localparam int LD = 4;
    localparam int BW = 16;
    localparam int PL = 4;
    localparam int NW = $clog2(LS);
    localparam int LW = $clog2(LD);
    localparam int NWORDS = LS * LD;

    logic          clk = 1'b0;
    logic          rst;
    logic          start, load_w, abort;
    logic          busy, done;
    logic          w_valid, w_ready;
    logic [BW-1:0] w_data;
    logic          x_valid, x_ready;
    logic [BW-1:0] x_data;
    logic          y_valid, y_ready;
    logic [BW-1:0] y_data;
    logic          nn_rst, nn_write_enable, nn_input_select;
    logic [LW-1:0] nn_layer;
    logic [NW-1:0] nn_node;
    logic [BW-1:0] nn_x, nn_y;
`ifdef NNSEQ_PERF_CNT_EN
    logic [31:0]   cycle_count;
`endif

    // Stimulus tables and datapath result model: nn_y is result[nn_node].
    logic [BW-1:0] wv  [NWORDS];
    logic [BW-1:0] xv  [LS];
    logic [BW-1:0] res [LS];

    assign nn_y = res[nn_node];

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    nn_sequencer #(
        .LAYER_SIZE  (LS),
        .LAYER_DEPTH (LD),
        .BIT_SIZE    (BW),
        .PIPE_LAT    (PL)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .start           (start),
        .load_w          (load_w),
        .abort           (abort),
        .busy            (busy),
        .done            (done),
        .w_valid         (w_valid),
        .w_ready         (w_ready),
        .w_data          (w_data),
        .x_valid         (x_valid),
        .x_ready         (x_ready),
        .x_data          (x_data),
        .y_valid         (y_valid),
        .y_ready         (y_ready),
        .y_data          (y_data),
        .nn_rst          (nn_rst),
        .nn_write_enable (nn_write_enable),
        .nn_input_select (nn_input_select),
        .nn_layer        (nn_layer),
        .nn_node         (nn_node),
        .nn_x            (nn_x),
        .nn_y            (nn_y)
`ifdef NNSEQ_PERF_CNT_EN
        ,
        .cycle_count     (cycle_count)
`endif
    );

    // Observation log, filled at negedges while out of reset.
    logic [LW+NW+BW-1:0] wr_q [$];
    logic [BW-1:0]       nnx_q [$];
    logic [BW-1:0]       y_q [$];
    int  nn_rst_cyc = 0, done_cyc = 0, busy_cyc = 0, run_cyc = 0;
    int  sel_bad = 0, stab_bad = 0;
    bit  x_pend = 1'b0, y_hold = 1'b0;
    logic [BW-1:0] y_last = '0;

    always @(negedge clk) begin
        if (!rst) begin
            if (nn_write_enable) wr_q.push_back({nn_layer, nn_node, nn_x});
            if (x_pend) nnx_q.push_back(nn_x);
            if (y_valid && y_ready && !abort) y_q.push_back(y_data);
            if (nn_rst) nn_rst_cyc <= nn_rst_cyc + 1;
            if (done) done_cyc <= done_cyc + 1;
            if (busy) busy_cyc <= busy_cyc + 1;
            if (busy && !nn_input_select && !y_valid) run_cyc <= run_cyc + 1;
            if (x_valid && x_ready && !nn_input_select) sel_bad <= sel_bad + 1;
            if (y_hold && (y_data !== y_last || !y_valid)) stab_bad <= stab_bad + 1;
            x_pend <= x_valid && x_ready && !abort;
            y_hold <= y_valid && !y_ready && !abort;
            y_last <= y_data;
        end
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic send_w(input logic [BW-1:0] d);
        int n;
        n = 0;
        w_valid = 1'b1;
        w_data  = d;
        @(negedge clk);
        while (!w_ready && n < 40) begin @(negedge clk); n++; end
        chk("w_accept", 32'(w_ready), 32'd1);
        @(posedge clk); #1;
        w_valid = 1'b0;
    endtask

    task automatic send_x(input logic [BW-1:0] d);
        int n;
        n = 0;
        x_valid = 1'b1;
        x_data  = d;
        @(negedge clk);
        while (!x_ready && n < 40) begin @(negedge clk); n++; end
        chk("x_accept", 32'(x_ready), 32'd1);
        @(posedge clk); #1;
        x_valid = 1'b0;
    endtask

    task automatic recv_y(input int hold);
        int n;
        n = 0;
        if (hold > 0) begin
            y_ready = 1'b0;
            repeat (hold) @(posedge clk);
            #1;
        end
        y_ready = 1'b1;
        @(negedge clk);
        while (!y_valid && n < 40) begin @(negedge clk); n++; end
        chk("y_accept", 32'(y_valid), 32'd1);
        @(posedge clk); #1;
    endtask

    // One complete inference from IDLE; checks writes, inputs, results and timing.
    task automatic run_inf(input bit lw, input int stall_at, input int bp_at, input string tag);
        int b_wr, b_x, b_y, b_rst, b_done, b_run, b_busy;
        b_wr = wr_q.size();   b_x = nnx_q.size();  b_y = y_q.size();
        b_rst = nn_rst_cyc;   b_done = done_cyc;   b_run = run_cyc;  b_busy = busy_cyc;
        start = 1'b1; load_w = lw;
        @(posedge clk); #1;
        start = 1'b0; load_w = 1'b0;
        if (lw) begin
            for (int k = 0; k < NWORDS; k++) begin
                send_w(wv[k]);
                if (k == stall_at) begin
                    repeat (3) @(posedge clk);
                    #1;
                end
            end
        end
        for (int k = 0; k < LS; k++) send_x(xv[k]);
        for (int k = 0; k < LS; k++) recv_y((k == bp_at) ? 5 : 0);
        @(negedge clk);
        chk($sformatf("%s done_pulse", tag), 32'(done), 32'd1);
        chk($sformatf("%s busy_low", tag), 32'(busy), 32'd0);
        chk($sformatf("%s sel_idle", tag), 32'(nn_input_select), 32'd1);
`ifdef NNSEQ_PERF_CNT_EN
        chk($sformatf("%s cycle_count", tag), cycle_count, 32'(busy_cyc - b_busy));
`endif
        @(negedge clk);
        chk($sformatf("%s done_once", tag), 32'(done), 32'd0);
        @(posedge clk); #1;
        y_ready = 1'b0;
        chk($sformatf("%s wr_count", tag), 32'(wr_q.size() - b_wr), lw ? 32'(NWORDS) : 32'd0);
        if (lw) begin
            for (int k = 0; k < NWORDS; k++) begin
                chk($sformatf("%s wr%0d", tag, k),
                    32'((b_wr + k < wr_q.size()) ? wr_q[b_wr + k] : 'x),
                    32'({LW'(k / LS), NW'(k % LS), wv[k]}));
            end
        end
        chk($sformatf("%s nn_rst_cycles", tag), 32'(nn_rst_cyc - b_rst), 32'd1);
        chk($sformatf("%s x_count", tag), 32'(nnx_q.size() - b_x), 32'(LS));
        chk($sformatf("%s y_count", tag), 32'(y_q.size() - b_y), 32'(LS));
        for (int k = 0; k < LS; k++) begin
            chk($sformatf("%s nn_x%0d", tag, k),
                32'((b_x + k < nnx_q.size()) ? nnx_q[b_x + k] : 'x), 32'(xv[k]));
            chk($sformatf("%s y%0d", tag, k),
                32'((b_y + k < y_q.size()) ? y_q[b_y + k] : 'x), 32'(res[k]));
        end
        chk($sformatf("%s run_cycles", tag), 32'(run_cyc - b_run), 32'(PL));
        chk($sformatf("%s done_count", tag), 32'(done_cyc - b_done), 32'd1);
        chk($sformatf("%s sel_during_feed", tag), 32'(sel_bad), 32'd0);
        chk($sformatf("%s y_stable", tag), 32'(stab_bad), 32'd0);
    endtask

    task automatic randomize_tables();
        for (int k = 0; k < NWORDS; k++) wv[k] = BW'($urandom);
        for (int k = 0; k < LS; k++) begin
            xv[k]  = BW'($urandom);
            res[k] = BW'($urandom);
        end
    endtask

    task automatic chk_reset_vals(input string tag);
        chk({tag, " busy"}, 32'(busy), 32'd0);
        chk({tag, " done"}, 32'(done), 32'd0);
        chk({tag, " w_ready"}, 32'(w_ready), 32'd0);
        chk({tag, " x_ready"}, 32'(x_ready), 32'd0);
        chk({tag, " y_valid"}, 32'(y_valid), 32'd0);
        chk({tag, " nn_rst"}, 32'(nn_rst), 32'd0);
        chk({tag, " nn_we"}, 32'(nn_write_enable), 32'd0);
        chk({tag, " nn_sel"}, 32'(nn_input_select), 32'd1);
        chk({tag, " nn_layer"}, 32'(nn_layer), 32'd0);
        chk({tag, " nn_node"}, 32'(nn_node), 32'd0);
        chk({tag, " nn_x"}, 32'(nn_x), 32'd0);
        chk({tag, " y_data"}, 32'(y_data), 32'd0);
`ifdef NNSEQ_PERF_CNT_EN
        chk({tag, " cycle_count"}, cycle_count, 32'd0);
`endif
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog expired before summary");
        $fatal(1, "watchdog");
    end

    initial begin
        rst = 1'b1; start = 1'b0; load_w = 1'b0; abort = 1'b0;
        w_valid = 1'b0; w_data = '0; x_valid = 1'b0; x_data = '0; y_ready = 1'b0;
        for (int k = 0; k < LS; k++) res[k] = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk_reset_vals("reset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;

        // Directed weight load, words 1..16, then x = 3,7,11,15.
        for (int k = 0; k < NWORDS; k++) wv[k] = BW'(k + 1);
        xv[0] = 16'd3; xv[1] = 16'd7; xv[2] = 16'd11; xv[3] = 16'd15;
        for (int k = 0; k < LS; k++) res[k] = BW'($urandom);
        run_inf(1'b1, -1, -1, "load");

        // Load with a 3-cycle stall after the fifth word.
        randomize_tables();
        run_inf(1'b1, 4, -1, "stall");

        // Inference without reload.
        xv[0] = 16'd3; xv[1] = 16'd7; xv[2] = 16'd11; xv[3] = 16'd15;
        run_inf(1'b0, -1, -1, "noreload");

        // Result backpressure in the middle of DRAIN.
        randomize_tables();
        run_inf(1'b0, -1, 2, "backpressure");

        // Abort during FEED after two inputs; a third word is offered with abort.
        randomize_tables();
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        send_x(xv[0]);
        send_x(xv[1]);
        abort = 1'b1; x_valid = 1'b1; x_data = ~xv[1];
        @(posedge clk); #1;
        abort = 1'b0; x_valid = 1'b0;
        @(negedge clk);
        chk("abort nn_rst", 32'(nn_rst), 32'd1);
        chk("abort x_ready", 32'(x_ready), 32'd0);
        chk("abort nn_we", 32'(nn_write_enable), 32'd0);
        chk("abort nn_node", 32'(nn_node), 32'd0);
        chk("abort nn_x_kept", 32'(nn_x), 32'(xv[1]));
        chk("abort busy", 32'(busy), 32'd1);
        @(negedge clk);
        chk("abort idle", 32'(busy), 32'd0);
        chk("abort nn_rst_end", 32'(nn_rst), 32'd0);
        @(posedge clk); #1;
        run_inf(1'b0, -1, -1, "after_abort");

        // Asynchronous reset in the middle of a weight load, at index (2,1).
        randomize_tables();
        start = 1'b1; load_w = 1'b1;
        @(posedge clk); #1;
        start = 1'b0; load_w = 1'b0;
        for (int k = 0; k < 2 * LS + 1; k++) send_w(wv[k]);
        #2 rst = 1'b1;
        #1;
        chk_reset_vals("midreset");
        @(posedge clk); #1;
        rst = 1'b0;
        @(posedge clk); #1;
        run_inf(1'b1, -1, -1, "after_reset");

        // Randomised inferences.
        for (int r = 0; r < 4; r++) begin
            randomize_tables();
            run_inf(1'($urandom_range(0, 1)), int'($urandom_range(0, NWORDS - 1)),
                    int'($urandom_range(0, LS - 1)), $sformatf("rand%0d", r));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/nn_sequencer.md
Name: nn_sequencer

Overview:
- Controller that drives the neural_network datapath through one full inference: weight load, state clear, input feed, compute wait, result drain.
- Replaces hand-timed stimulus with valid/ready streams, so a host or DMA sits upstream and the datapath sits downstream.
- One instance per neural_network; all nn_* outputs connect directly to the datapath ports of the same purpose.

Parameters:
- LAYER_SIZE, 4, nodes per layer; power of two, >=2.
- LAYER_DEPTH, 4, number of layers; power of two, >=2.
- BIT_SIZE, 16, data word width.
- PIPE_LAT, 4, cycles spent in RUN between the last fed input and the first valid y; >=1.

Ports:
- clk  in  1  clock; all state on rising edge.
- rst  in  1  asynchronous, active-high reset.
- start  in  1  single-cycle request to begin an inference; sampled only in IDLE.
- load_w  in  1  sampled with start; 1 = reload weights before computing.
- abort  in  1  synchronous abort; takes effect from any non-IDLE state.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on the final DRAIN handshake.
- w_valid  in  1  weight word valid.
- w_ready  out  1  weight word accepted when w_valid & w_ready.
- w_data  in  BIT_SIZE  weight word.
- x_valid  in  1  input word valid.
- x_ready  out  1  input word accepted when x_valid & x_ready.
- x_data  in  BIT_SIZE  input word.
- y_valid  out  1  result word valid.
- y_ready  in  1  result word consumed when y_valid & y_ready.
- y_data  out  BIT_SIZE  result word.
- nn_rst  out  1  datapath clear strobe.
- nn_write_enable  out  1  datapath weight write enable.
- nn_input_select  out  1  1 = datapath takes x, 0 = datapath recirculates.
- nn_layer  out  $clog2(LAYER_DEPTH)  datapath layer index.
- nn_node  out  $clog2(LAYER_SIZE)  datapath node index.
- nn_x  out  BIT_SIZE  datapath input word.
- nn_y  in  BIT_SIZE  datapath output word.

Behaviour:
- Reset values (rst=1, asynchronous):
  - State = IDLE.
  - busy, done, w_ready, x_ready, y_valid, nn_rst, nn_write_enable = 0.
  - nn_input_select = 1.
  - nn_layer, nn_node, nn_x, y_data = 0.
- States: IDLE, LOAD_W, CLEAR, FEED, RUN, DRAIN.
- IDLE:
  - start=1 with load_w=1 -> LOAD_W.
  - start=1 with load_w=0 -> CLEAR.
  - start is ignored in every other state.
- LOAD_W:
  - w_ready=1 throughout the state.
  - On each handshake, register nn_write_enable=1 for exactly one cycle, with nn_x=w_data and the current layer/node.
  - Then advance node. When node wraps LAYER_SIZE-1 -> 0, increment layer.
  - The handshake at layer=LAYER_DEPTH-1, node=LAYER_SIZE-1 -> CLEAR, with indices reset to 0.
  - Stalls, i.e. w_valid=0, hold all indices.
  - Exactly LAYER_DEPTH*LAYER_SIZE handshakes occur.
- CLEAR:
  - nn_rst=1 for exactly 1 cycle, with nn_input_select=1.
  - Next state is FEED.
- FEED:
  - x_ready=1, nn_input_select=1.
  - Each handshake drives nn_x=x_data the following cycle and increments node.
  - After LAYER_SIZE handshakes -> RUN, with nn_input_select dropping to 0 in the same cycle the state changes.
- RUN:
  - Down-counter loads PIPE_LAT and decrements each cycle.
  - At 0 -> DRAIN.
- DRAIN:
  - y_valid=1, y_data=nn_y registered.
  - y_data holds stable while y_valid & !y_ready.
  - LAYER_SIZE handshakes, node stepping 0..LAYER_SIZE-1.
  - The last handshake pulses done and returns to IDLE, with nn_input_select=1.
- Abort:
  - abort=1 in any non-IDLE state -> next cycle nn_rst=1, all ready/valid/enable outputs 0, indices 0.
  - The cycle after that -> IDLE.
  - abort outranks a same-cycle handshake; that handshake does not count.
- Outputs: registered; w_ready, x_ready and y_valid are decoded from the state register.

Optional Feature:
- Macro NNSEQ_PERF_CNT_EN.
- Defined:
  - Adds output cycle_count, 32 bits.
  - Cleared on rst and on the start acceptance cycle.
  - Increments every busy cycle.
  - Saturates at 2^32-1 and holds its value in IDLE.
- Undefined: the port and counter are absent; all other behaviour is identical.

Decomposition:
- Package nn_seq_pkg holds:
  - state_t enum.
  - Index-width localparams derived from LAYER_SIZE/LAYER_DEPTH.
  - PERF_W=32.
- Sub-module nn_idx_counter holds the 2-D layer/node counter with enable, clear, node wrap and last-index flag.
- nn_idx_counter is shared by LOAD_W, FEED and DRAIN.

Test Plan (defaults: LAYER_SIZE=4, LAYER_DEPTH=4, BIT_SIZE=16, PIPE_LAT=4):
- Weight load: start with load_w=1, 16 back-to-back w words 0x0001..0x0010 -> 16 nn_write_enable pulses; (layer,node) goes (0,0)..(3,3) in order, nn_x matches each word; then a 1-cycle nn_rst.
- Stalled load: w_valid low for 3 cycles after word 5 -> indices hold at (1,1); still exactly 16 writes.
- Inference without reload: start with load_w=0, x = 3,7,11,15 -> nn_rst 1 cycle, 4 x handshakes with nn_input_select=1, nn_input_select low for 4 RUN cycles, 4 y outputs, done pulses once and busy falls the next cycle.
- Output backpressure: y_ready low for 5 cycles mid-DRAIN -> y_data stable and y_valid held; done only after the 4th handshake.
- Abort: abort during FEED after 2 inputs -> nn_rst pulse, IDLE two cycles later; a following start with load_w=0 completes normally.
- Reset mid-LOAD_W at (2,1) -> outputs take reset values immediately; nn_input_select=1. With NNSEQ_PERF_CNT_EN defined, cycle_count=0 after reset and equals total busy cycles after a full run.
